// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  typedef enum logic {
    S_IDLE = ST_IDLE,
    S_BUSY = ST_BUSY
  } state_t;

  // Binary requester index to one-hot grant vector.
  function automatic logic [N_REQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating descending priority pick: the first set req bit at start, start-1, ... with wrap 0->7.
module rr_prio_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  id
);

  // rot[k] is the request sitting k steps below start (mod N_REQ).
  logic [N_REQ-1:0] rot;

  for (genvar k = 0; k < N_REQ; k++) begin : g_rot
    assign rot[k] = req[start - ID_W'(k)];
  end

  // Lowest k in rot wins; scanning high-to-low lets the nearest hit overwrite.
  always_comb begin
    id    = '0;
    found = |req;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) id = start - ID_W'(k);
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with hold-for-duration grants and a contended hold limit.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             preempt
);

  localparam int        HW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  localparam bit        TO_EN = (MAX_HOLD != 0);

  state_t          state, state_nx;
  logic [ID_W-1:0] ptr, ptr_nx;
  logic [HW-1:0]   hcnt, hcnt_nx;
  logic [N_REQ-1:0] grant_nx;
  logic [ID_W-1:0] grant_id_nx;
  logic            grant_valid_nx, preempt_nx;

  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            owner_req, others, at_limit;

  rr_prio_pick u_pick (
    .req   (req),
    .start (ptr),
    .found (pick_found),
    .id    (pick_id)
  );

  assign owner_req = req[grant_id];
  assign others    = |(req & ~grant);
  assign at_limit  = TO_EN && (hcnt == HMAX);

  // Next-state and next-output logic; default is to hold everything.
  always_comb begin
    state_nx       = state;
    ptr_nx         = ptr;
    hcnt_nx        = hcnt;
    grant_nx       = grant;
    grant_id_nx    = grant_id;
    grant_valid_nx = grant_valid;
    preempt_nx     = 1'b0;
    case (state)
      S_IDLE: begin
        if (en && pick_found) begin
          state_nx       = S_BUSY;
          grant_nx       = id2onehot(pick_id);
          grant_id_nx    = pick_id;
          grant_valid_nx = 1'b1;
          hcnt_nx        = HW'(1);
          ptr_nx         = pick_id - ID_W'(1);
        end
      end
      S_BUSY: begin
        // Owner dropping wins over timeout, so a simultaneous drop never preempts.
        if (!owner_req || (at_limit && others)) begin
          state_nx       = S_IDLE;
          grant_nx       = '0;
          grant_id_nx    = '0;
          grant_valid_nx = 1'b0;
          hcnt_nx        = '0;
          preempt_nx     = owner_req;
        end else if (TO_EN && (hcnt != HMAX)) begin
          hcnt_nx = hcnt + HW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, pointer, hold counter and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= ID_W'(N_REQ - 1);
      hcnt        <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      state       <= state_nx;
      ptr         <= ptr_nx;
      hcnt        <= hcnt_nx;
      grant       <= grant_nx;
      grant_id    <= grant_id_nx;
      grant_valid <= grant_valid_nx;
      preempt     <= preempt_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed scoreboard bench for rr_arbiter_8 with a hold limit of 4.
module tb_rr_arbiter_8;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] id;
    logic       valid;
    logic       preempt;
  } exp_t;

  logic       clk, rst, en;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid, preempt;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic valid, input logic [2:0] id, input logic pre);
    exp_t e;
    e.grant   = valid ? (8'h01 << id) : 8'h00;
    e.id      = valid ? id : 3'd0;
    e.valid   = valid;
    e.preempt = pre;
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".grant"},   32'(grant),       32'(e.grant));
    chk({tag, ".id"},      32'(grant_id),    32'(e.id));
    chk({tag, ".valid"},   32'(grant_valid), 32'(e.valid));
    chk({tag, ".preempt"}, 32'(preempt),     32'(e.preempt));
  endtask

  // Drive one cycle of stimulus, push the expected post-edge outputs, then pop and compare.
  task automatic step(input string tag, input logic [7:0] r, input logic e_n,
                      input logic valid, input logic [2:0] id, input logic pre);
    exp_t e;
    req = r;
    en  = e_n;
    sb.push_back(mk(valid, id, pre));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    cmp_out(tag, e);
  endtask

  initial begin
    logic [2:0] order [9];
    logic [2:0] w;
    rst = 1'b1; en = 1'b0; req = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    cmp_out("reset", mk(1'b0, 3'd0, 1'b0));
    rst = 1'b0;

    // Fresh start: index 7 wins, then 0 after one idle cycle.
    step("s1_g7",   8'h81, 1'b1, 1'b1, 3'd7, 1'b0);
    step("s1_h7",   8'h81, 1'b1, 1'b1, 3'd7, 1'b0);
    step("s1_rel",  8'h01, 1'b1, 1'b0, 3'd0, 1'b0);
    step("s1_g0",   8'h01, 1'b1, 1'b1, 3'd0, 1'b0);
    step("s1_idle", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // All requesting, each owner holds two cycles: strict descending rotation.
    order = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    for (int i = 0; i < 9; i++) begin
      w = order[i];
      step("s2_g",   8'hFF, 1'b1, 1'b1, w, 1'b0);
      step("s2_h",   8'hFF, 1'b1, 1'b1, w, 1'b0);
      step("s2_rel", 8'hFF & ~(8'h01 << w), 1'b1, 1'b0, 3'd0, 1'b0);
    end

    // Contended timeout: 3 for 4 cycles, preempt, 2 for 4 cycles, preempt, 3 again.
    for (int i = 0; i < 4; i++) step("s3_g3", 8'h0C, 1'b1, 1'b1, 3'd3, 1'b0);
    step("s3_pre3", 8'h0C, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 4; i++) step("s3_g2", 8'h0C, 1'b1, 1'b1, 3'd2, 1'b0);
    step("s3_pre2", 8'h0C, 1'b1, 1'b0, 3'd0, 1'b1);
    step("s3_g3b",  8'h0C, 1'b1, 1'b1, 3'd3, 1'b0);
    step("s3_rel",  8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Uncontended: grant kept past the limit, no preempt.
    for (int i = 0; i < 21; i++) step("s4_g5", 8'h20, 1'b1, 1'b1, 3'd5, 1'b0);
    step("s4_rel", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Enable gating in IDLE only.
    for (int i = 0; i < 3; i++) step("s5_off", 8'h10, 1'b0, 1'b0, 3'd0, 1'b0);
    step("s5_g4", 8'h10, 1'b1, 1'b1, 3'd4, 1'b0);
    step("s5_h4", 8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
    step("s5_h4", 8'h10, 1'b0, 1'b1, 3'd4, 1'b0);
    step("s5_rel", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);

    // Owner drops exactly on the limit cycle: normal release, no preempt.
    for (int i = 0; i < 4; i++) step("s6_g3", 8'h0C, 1'b1, 1'b1, 3'd3, 1'b0);
    step("s6_rel", 8'h04, 1'b1, 1'b0, 3'd0, 1'b0);
    step("s6_g2",  8'h04, 1'b1, 1'b1, 3'd2, 1'b0);
    step("s6_idle", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0);

    // Asynchronous reset mid-grant, then pointer back at 7.
    step("s7_g6", 8'h40, 1'b1, 1'b1, 3'd6, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    cmp_out("s7_async", mk(1'b0, 3'd0, 1'b0));
    req = 8'h00;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    cmp_out("s7_post", mk(1'b0, 3'd0, 1'b0));
    step("s7_g6b", 8'h41, 1'b1, 1'b1, 3'd6, 1'b0);
    step("s7_rel", 8'h01, 1'b1, 1'b0, 3'd0, 1'b0);
    step("s7_g0",  8'h01, 1'b1, 1'b1, 3'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
